// File: rtl/pc_stream_pkg.sv
// Shared sizing helpers and entry layout for the result stream buffer.
// The result width grows with log2 of the number of summed coefficients.
package pc_stream_pkg;

  localparam int DROP_W   = 8;
  localparam int DROP_MAX = 255;

  function automatic int res_w(input int bits, input int cges);
    return $clog2(cges) + bits;
  endfunction

  localparam int RES_W_DEF = res_w(32, 49);

  typedef struct packed {
    logic                 over;
    logic [RES_W_DEF-1:0] data;
  } entry_t;

endpackage

// File: rtl/result_stream_buffer_if.sv
// Producer/consumer handshake bundle around the result stream buffer.
// The slave modport is the buffer itself; master is the surrounding logic.
interface result_stream_buffer_if #(
  parameter int MAX = 38
);
  logic           in_valid;
  logic [MAX-1:0] in_data;
  logic [MAX-1:0] threshold;
  logic           out_ready;
  logic           out_valid;
  logic [MAX-1:0] out_data;
  logic           out_over;

  modport slave (
    input  in_valid, in_data, threshold, out_ready,
    output out_valid, out_data, out_over
  );

  modport master (
    output in_valid, in_data, threshold, out_ready,
    input  out_valid, out_data, out_over
  );
endinterface

// File: rtl/stream_fifo_mem.sv
// Plain register array for FIFO storage: one write port, one async read port.
// Storage is never reset; only the pointers decide what is valid.
module stream_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 39,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/result_stream_buffer.sv
// Captures CPA results into a small FWFT FIFO, tags them against a threshold,
// tracks the running peak and counts results lost while the consumer stalls.
module result_stream_buffer
  import pc_stream_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int CGES  = 49,
  parameter int DEPTH = 4,
  localparam int MAX   = res_w(BITS, CGES),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  input  logic                  clr,
  result_stream_buffer_if.slave bus,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic [DROP_W-1:0]     drop_cnt,
  output logic [MAX-1:0]        peak
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_PART  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef struct packed {
    logic           over;
    logic [MAX-1:0] data;
  } ent_t;

  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [MAX-1:0]    peak_q, peak_d;
  ent_t              head_q, head_d;
  ent_t              wdata, rdata;
  logic [1:0]        occ;
  logic              pop, push, drop;

  always_comb begin
    occ = ST_PART;
    if (count_q == '0)                       occ = ST_EMPTY;
    else if (count_q == CNT_W'(DEPTH))       occ = ST_FULL;
  end

  assign pop   = (occ != ST_EMPTY) & bus.out_ready;
  assign push  = bus.in_valid & ((occ != ST_FULL) | pop);
  assign drop  = bus.in_valid & (occ == ST_FULL) & ~pop;
  assign wdata = '{over: (bus.in_data > bus.threshold), data: bus.in_data};

  // Storage is read at the next read pointer so the head register can be
  // loaded with the entry that will be at the head after this edge.
  stream_fifo_mem #(.DEPTH(DEPTH), .W(MAX + 1)) u_mem (
    .clk   (CLK),
    .we    (push & ~clr),
    .waddr (wr_q),
    .wdata (wdata),
    .raddr (rd_d),
    .rdata (rdata)
  );

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    peak_d  = peak_q;
    head_d  = head_q;
    if (clr) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      drop_d  = '0;
      peak_d  = '0;
      head_d  = '0;
    end else begin
      if (push) wr_d = wr_q + PTR_W'(1);
      if (pop)  rd_d = rd_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != DROP_W'(DROP_MAX)) drop_d = drop_q + DROP_W'(1);
      end
      if (push && (bus.in_data > peak_q)) peak_d = bus.in_data;
      // Entry landing on the new head this edge is not in storage yet.
      if (count_d != '0) head_d = (push && (wr_q == rd_d)) ? wdata : rdata;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
      peak_q  <= '0;
      head_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      peak_q  <= peak_d;
      head_q  <= head_d;
    end
  end

  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = head_q.data;
  assign bus.out_over  = head_q.over;
  assign count         = count_q;
  assign overflow      = ovf_q;
  assign drop_cnt      = drop_q;
  assign peak          = peak_q;

endmodule

// File: tb/tb_result_stream_buffer.sv
// Directed bench for result_stream_buffer: fill/drain, drops, threshold tags,
// saturation, clear priority and asynchronous reset.
module tb_result_stream_buffer;

  localparam int MAX = 38;

  logic           CLK = 1'b0;
  logic           reset_n;
  logic           clr;
  logic [2:0]     count;
  logic           overflow;
  logic [7:0]     drop_cnt;
  logic [MAX-1:0] peak;

  int vectors = 0;
  int errors  = 0;

  result_stream_buffer_if #(.MAX(MAX)) bus ();

  result_stream_buffer #(.BITS(32), .CGES(49), .DEPTH(4)) dut (
    .CLK      (CLK),
    .reset_n  (reset_n),
    .clr      (clr),
    .bus      (bus),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .peak     (peak)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [MAX-1:0] v);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    @(negedge CLK);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge CLK);
    clr = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.threshold = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_count", count, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_peak", peak, 0);
    reset_n = 1'b1;
    @(negedge CLK);

    // single result
    bus.threshold = 50;
    push(100);
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_data", bus.out_data, 100);
    chk("t1_over", bus.out_over, 1);
    chk("t1_count", count, 1);
    chk("t1_peak", peak, 100);
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.out_ready = 1'b0;
    chk("t1_count_pop", count, 0);
    chk("t1_valid_pop", bus.out_valid, 0);
    chk("t1_data_hold", bus.out_data, 100);
    pulse_clr();
    chk("clr_peak", peak, 0);
    chk("clr_data", bus.out_data, 0);

    // fill and drop
    push(10); push(20); push(30); push(40); push(50); push(60);
    chk("t2_count", count, 4);
    chk("t2_ovf", overflow, 1);
    chk("t2_drop", drop_cnt, 2);
    chk("t2_peak", peak, 40);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_drain", bus.out_data, 64'(10 * (k + 1)));
      @(negedge CLK);
    end
    bus.out_ready = 1'b0;
    chk("t2_empty", count, 0);
    chk("t2_valid", bus.out_valid, 0);

    // full with simultaneous push and pop
    pulse_clr();
    push(1); push(2); push(3); push(4);
    chk("t3_full", count, 4);
    bus.in_valid  = 1'b1;
    bus.in_data   = 99;
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.in_valid  = 1'b0;
    chk("t3_count", count, 4);
    chk("t3_drop", drop_cnt, 0);
    chk("t3_ovf", overflow, 0);
    chk("t3_head", bus.out_data, 2);
    chk("t3_d2", bus.out_data, 2); @(negedge CLK);
    chk("t3_d3", bus.out_data, 3); @(negedge CLK);
    chk("t3_d4", bus.out_data, 4); @(negedge CLK);
    chk("t3_d99", bus.out_data, 99); @(negedge CLK);
    bus.out_ready = 1'b0;
    chk("t3_empty", count, 0);
    chk("t3_peak", peak, 99);

    // threshold edge
    bus.threshold = 77;
    push(77); push(78);
    bus.threshold = 0;
    @(negedge CLK);
    chk("t4_d77", bus.out_data, 77);
    chk("t4_o77", bus.out_over, 0);
    bus.out_ready = 1'b1;
    @(negedge CLK);
    chk("t4_d78", bus.out_data, 78);
    chk("t4_o78", bus.out_over, 1);
    @(negedge CLK);
    bus.out_ready = 1'b0;
    chk("t4_empty", count, 0);

    // saturation and clear priority
    push(1); push(2); push(3); push(4);
    bus.in_valid = 1'b1;
    bus.in_data  = 200;
    repeat (300) @(negedge CLK);
    bus.in_valid = 1'b0;
    chk("t5_drop", drop_cnt, 255);
    chk("t5_ovf", overflow, 1);
    chk("t5_count", count, 4);
    chk("t5_peak", peak, 99);
    clr          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 500;
    @(negedge CLK);
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    chk("t5_clr_count", count, 0);
    chk("t5_clr_drop", drop_cnt, 0);
    chk("t5_clr_ovf", overflow, 0);
    chk("t5_clr_peak", peak, 0);
    chk("t5_clr_valid", bus.out_valid, 0);
    chk("t5_clr_data", bus.out_data, 0);

    // asynchronous reset between edges
    bus.threshold = 5;
    push(5); push(6); push(7);
    chk("t6_count", count, 3);
    chk("t6_peak", peak, 7);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_count_rst", count, 0);
    chk("t6_valid_rst", bus.out_valid, 0);
    chk("t6_data_rst", bus.out_data, 0);
    chk("t6_over_rst", bus.out_over, 0);
    chk("t6_ovf_rst", overflow, 0);
    chk("t6_drop_rst", drop_cnt, 0);
    chk("t6_peak_rst", peak, 0);
    @(negedge CLK);
    reset_n = 1'b1;
    @(negedge CLK);
    push(9);
    chk("t6_recover_data", bus.out_data, 9);
    chk("t6_recover_over", bus.out_over, 1);
    chk("t6_recover_count", count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
